// File: rtl/sound_mix_filter.sv
// Two-source sound mixer: per-source Q4.4 gain on one time-shared multiplier,
// saturating sum and an optional first-order IIR low-pass on each output-rate strobe.
module sound_mix_filter #(
    parameter int FILT_SHIFT = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_sample_i,
    input  logic [15:0] fm_in_i,
    input  logic [15:0] pcm_in_i,
    input  logic [7:0]  fm_gain_i,
    input  logic [7:0]  pcm_gain_i,
    input  logic        filt_en_i,
    output logic [15:0] sample_out_o,
    output logic        sample_valid_o,
    output logic [7:0]  clip_count_o,
    output logic        overrun_o
);

    localparam int AW = 16 + FILT_SHIFT;

    typedef enum logic [2:0] {IDLE, MUL_FM, MUL_PCM, SUM, FILT, OUT} state_t;

    state_t state_q, state_d;
    logic signed [15:0]   fm_q, fm_d, pcm_q, pcm_d;
    logic [7:0]           fmGain_q, fmGain_d, pcmGain_q, pcmGain_d;
    logic                 filtEn_q, filtEn_d;
    logic signed [20:0]   pf_q, pf_d, pp_q, pp_d;
    logic signed [15:0]   x_q, x_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [15:0]          sampleOut_q, sampleOut_d;
    logic [7:0]           clipCount_q, clipCount_d;
    logic                 overrun_q, overrun_d;

    logic signed [15:0]   mulA;
    logic [7:0]           mulB;
    logic signed [24:0]   mulProd;
    logic signed [20:0]   mulShift;
    logic signed [21:0]   sumFull;
    logic signed [15:0]   sumSat;
    logic                 sumClipped;
    logic signed [AW+1:0] accExt;
    logic signed [AW+1:0] accNext;

    // One multiplier serves both paths; the FSM state picks the operands.
    assign mulA     = (state_q == MUL_PCM) ? pcm_q : fm_q;
    assign mulB     = (state_q == MUL_PCM) ? pcmGain_q : fmGain_q;
    assign mulProd  = $signed({{9{mulA[15]}}, mulA}) * $signed({17'b0, mulB});
    assign mulShift = 21'(mulProd >>> 4);

    assign sumFull = $signed({pf_q[20], pf_q}) + $signed({pp_q[20], pp_q});

    always_comb begin
        sumSat     = 16'(sumFull);
        sumClipped = 1'b0;
        if (sumFull > 22'sd32767) begin
            sumSat     = 16'sh7FFF;
            sumClipped = 1'b1;
        end else if (sumFull < -22'sd32768) begin
            sumSat     = 16'sh8000;
            sumClipped = 1'b1;
        end
    end

    // Two guard bits keep acc + x - (acc >>> FILT_SHIFT) free of intermediate wrap.
    assign accExt  = (AW+2)'(acc_q);
    assign accNext = accExt + (AW+2)'(x_q) - (accExt >>> FILT_SHIFT);

    always_comb begin
        state_d        = state_q;
        fm_d           = fm_q;
        pcm_d          = pcm_q;
        fmGain_d       = fmGain_q;
        pcmGain_d      = pcmGain_q;
        filtEn_d       = filtEn_q;
        pf_d           = pf_q;
        pp_d           = pp_q;
        x_d            = x_q;
        acc_d          = acc_q;
        sampleOut_d    = sampleOut_q;
        clipCount_d    = clipCount_q;
        overrun_d      = overrun_q;
        sample_valid_o = 1'b0;

        if (ce_sample_i && state_q != IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ce_sample_i) begin
                    fm_d      = fm_in_i;
                    pcm_d     = pcm_in_i;
                    fmGain_d  = fm_gain_i;
                    pcmGain_d = pcm_gain_i;
                    filtEn_d  = filt_en_i;
                    state_d   = MUL_FM;
                end
            end
            MUL_FM: begin
                pf_d    = mulShift;
                state_d = MUL_PCM;
            end
            MUL_PCM: begin
                pp_d    = mulShift;
                state_d = SUM;
            end
            SUM: begin
                x_d = sumSat;
                if (sumClipped && clipCount_q != 8'hFF) begin
                    clipCount_d = clipCount_q + 8'd1;
                end
                state_d = FILT;
            end
            FILT: begin
                // sample_out is loaded here so the new value appears in the OUT cycle.
                if (filtEn_q) begin
                    acc_d       = AW'(accNext);
                    sampleOut_d = 16'(accNext >>> FILT_SHIFT);
                end else begin
                    acc_d       = AW'(x_q) <<< FILT_SHIFT;
                    sampleOut_d = x_q;
                end
                state_d = OUT;
            end
            OUT: begin
                sample_valid_o = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            fm_q        <= '0;
            pcm_q       <= '0;
            fmGain_q    <= '0;
            pcmGain_q   <= '0;
            filtEn_q    <= 1'b0;
            pf_q        <= '0;
            pp_q        <= '0;
            x_q         <= '0;
            acc_q       <= '0;
            sampleOut_q <= '0;
            clipCount_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fm_q        <= fm_d;
            pcm_q       <= pcm_d;
            fmGain_q    <= fmGain_d;
            pcmGain_q   <= pcmGain_d;
            filtEn_q    <= filtEn_d;
            pf_q        <= pf_d;
            pp_q        <= pp_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            sampleOut_q <= sampleOut_d;
            clipCount_q <= clipCount_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sample_out_o = sampleOut_q;
    assign clip_count_o = clipCount_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_sound_mix_filter.sv
// Self-checking bench for sound_mix_filter: directed and random samples compared
// against an integer model of the gain / saturate / IIR rules.
module tb_sound_mix_filter;

    localparam int FS = 3;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ce_sample_i = 1'b0;
    logic [15:0] fm_in_i = '0;
    logic [15:0] pcm_in_i = '0;
    logic [7:0]  fm_gain_i = '0;
    logic [7:0]  pcm_gain_i = '0;
    logic        filt_en_i = 1'b0;
    logic [15:0] sample_out_o;
    logic        sample_valid_o;
    logic [7:0]  clip_count_o;
    logic        overrun_o;

    int checks = 0;
    int errors = 0;
    int modelAcc = 0;
    int modelClip = 0;
    int expY;
    int lat;
    int validSeen;

    sound_mix_filter #(.FILT_SHIFT(FS)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ce_sample_i    (ce_sample_i),
        .fm_in_i        (fm_in_i),
        .pcm_in_i       (pcm_in_i),
        .fm_gain_i      (fm_gain_i),
        .pcm_gain_i     (pcm_gain_i),
        .filt_en_i      (filt_en_i),
        .sample_out_o   (sample_out_o),
        .sample_valid_o (sample_valid_o),
        .clip_count_o   (clip_count_o),
        .overrun_o      (overrun_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference model: plain integer arithmetic on one sample, updating filter and clip state.
    function automatic int modelStep(int fm, int pcm, int fg, int pg, int en);
        int pf, pp, s, x;
        pf = (fm * fg) >>> 4;
        pp = (pcm * pg) >>> 4;
        s  = pf + pp;
        x  = s;
        if (s > 32767) x = 32767;
        if (s < -32768) x = -32768;
        if (x != s && modelClip < 255) modelClip++;
        if (en != 0) begin
            modelAcc = modelAcc + x - (modelAcc >>> FS);
            return modelAcc >>> FS;
        end
        modelAcc = x * (1 << FS);
        return x;
    endfunction

    task automatic driveCe(input int fm, input int pcm, input int fg, input int pg, input int en);
        fm_in_i     = 16'(fm);
        pcm_in_i    = 16'(pcm);
        fm_gain_i   = 8'(fg);
        pcm_gain_i  = 8'(pg);
        filt_en_i   = (en != 0);
        ce_sample_i = 1'b1;
    endtask

    // Counts cycles from the strobe cycle until sample_valid; -1 if it never shows.
    task automatic waitValid(output int latency);
        latency = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            ce_sample_i = 1'b0;
            if (sample_valid_o === 1'b1) begin
                latency = c;
                break;
            end
        end
    endtask

    task automatic finishSample(input string tag);
        waitValid(lat);
        checkOutput({tag, ".latency"}, lat, 5);
        checkOutput({tag, ".sample"}, $signed(sample_out_o), expY);
        checkOutput({tag, ".clip"}, clip_count_o, modelClip);
        tick();
        checkOutput({tag, ".pulseWidth"}, sample_valid_o, 0);
    endtask

    task automatic applyStimulus(input string tag, input int fm, input int pcm,
                                 input int fg, input int pg, input int en);
        tick();
        driveCe(fm, pcm, fg, pg, en);
        expY = modelStep(fm, pcm, fg, pg, en);
        finishSample(tag);
    endtask

    task automatic doReset();
        reset = 1'b1;
        ce_sample_i = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        modelAcc = 0;
        modelClip = 0;
    endtask

    initial begin
        logic [15:0] rnd;

        // Reset state, then a strobe in the first cycle after reset release.
        repeat (3) tick();
        checkOutput("reset.sample", sample_out_o, 0);
        checkOutput("reset.valid", sample_valid_o, 0);
        checkOutput("reset.clip", clip_count_o, 0);
        checkOutput("reset.overrun", overrun_o, 0);
        reset = 1'b0;
        driveCe(1000, 2000, 'h10, 'h10, 0);
        expY = modelStep(1000, 2000, 'h10, 'h10, 0);
        checkOutput("unity.model", expY, 3000);
        finishSample("unity");

        applyStimulus("satPos", 30000, 30000, 'h10, 'h10, 0);
        checkOutput("satPos.value", $signed(sample_out_o), 32767);
        checkOutput("satPos.count", clip_count_o, 1);
        applyStimulus("satNeg", -32768, -32768, 'h10, 'h10, 0);
        checkOutput("satNeg.value", $signed(sample_out_o), -32768);
        checkOutput("satNeg.count", clip_count_o, 2);
        applyStimulus("gainHalf", -4000, 12345, 'h08, 'h00, 0);
        checkOutput("gainHalf.value", $signed(sample_out_o), -2000);
        applyStimulus("gainMax", 1000, -777, 'hFF, 'h00, 0);
        checkOutput("gainMax.value", $signed(sample_out_o), 15937);

        // IIR step response from a fresh accumulator, then bypass.
        doReset();
        applyStimulus("iir1", 8000, 0, 'h10, 'h10, 1);
        checkOutput("iir1.value", $signed(sample_out_o), 1000);
        applyStimulus("iir2", 8000, 0, 'h10, 'h10, 1);
        checkOutput("iir2.value", $signed(sample_out_o), 1875);
        applyStimulus("bypass", 8000, 0, 'h10, 'h10, 0);
        checkOutput("bypass.value", $signed(sample_out_o), 8000);
        applyStimulus("iir3", 8000, 0, 'h10, 'h10, 1);

        // Overrun: strobe at N, ignored strobe at N+3, accepted strobe at N+6.
        tick();
        checkOutput("ovr.before", overrun_o, 0);
        driveCe(-5000, 1200, 'h14, 'h0C, 1);
        expY = modelStep(-5000, 1200, 'h14, 'h0C, 1);
        tick();
        ce_sample_i = 1'b0;
        tick();
        tick();
        driveCe(31000, 31000, 'hFF, 'hFF, 0);
        tick();
        ce_sample_i = 1'b0;
        checkOutput("ovr.earlyValid", sample_valid_o, 0);
        tick();
        checkOutput("ovr.valid", sample_valid_o, 1);
        checkOutput("ovr.sample", $signed(sample_out_o), expY);
        checkOutput("ovr.sticky", overrun_o, 1);
        checkOutput("ovr.clip", clip_count_o, modelClip);
        tick();
        checkOutput("ovr.single", sample_valid_o, 0);
        driveCe(2500, -700, 'h10, 'h20, 1);
        expY = modelStep(2500, -700, 'h10, 'h20, 1);
        finishSample("ovrNext");
        checkOutput("ovr.stillSet", overrun_o, 1);

        // Reset mid-computation aborts the sample and clears the accumulator.
        tick();
        driveCe(9000, 9000, 'h10, 'h10, 1);
        tick();
        ce_sample_i = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        modelAcc = 0;
        modelClip = 0;
        validSeen = 0;
        for (int c = 0; c < 8; c++) begin
            if (sample_valid_o === 1'b1) validSeen++;
            tick();
        end
        checkOutput("abort.noValid", validSeen, 0);
        checkOutput("abort.sample", sample_out_o, 0);
        checkOutput("abort.overrun", overrun_o, 0);
        applyStimulus("abortNext", 8000, 0, 'h10, 'h10, 1);
        checkOutput("abortNext.value", $signed(sample_out_o), 1000);

        // Random samples against the model.
        for (int i = 0; i < 60; i++) begin
            rnd = 16'($urandom);
            applyStimulus("rand", $signed(rnd), $signed(16'($urandom)),
                          $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
        end

        // Clip counter saturation.
        doReset();
        for (int i = 0; i < 300; i++) begin
            applyStimulus("clipSat", 30000, 30000, 'h10, 'h10, 0);
        end
        checkOutput("clipSat.final", clip_count_o, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
